// File: rtl/chip_invaders_pkg.sv
// Shared types for the alien fleet engine: FSM states, pixel coordinates, pitch helper.
// No logic of its own, so no latency.
// No flow control; types only.
package chip_invaders_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARCH,
        DROP,
        CLEARED,
        LANDED
    } fleet_state_t;

    typedef logic [15:0] coord_t;

    localparam logic [3:0] LEVEL_MAX = 4'd15;

    // Cell pitches are powers of two, so a pixel offset maps to a cell index by a shift.
    function automatic int pitch_shift(input int pitch);
        return $clog2(pitch);
    endfunction

endpackage

// File: rtl/alien_fleet_controller_if.sv
// Bundle between the game-state controller / scan generator and the alien fleet engine.
// Wires only, no latency.
// No backpressure: pulses and queries are consumed in the cycle they are presented.
interface alien_fleet_controller_if
    import chip_invaders_pkg::*;
#(
    parameter int NUM_ROWS    = 2,
    parameter int NUM_COLUMNS = 4
);
    logic                                   frame_tick;
    logic                                   level_start;
    coord_t                                 scan_x;
    coord_t                                 scan_y;
    logic                                   hit_valid;
    coord_t                                 hit_x;
    coord_t                                 hit_y;
    logic                                   hit_ack;
    logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0]   alive_matrix;
    logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0]   armed_matrix;
    coord_t                                 fleet_x;
    coord_t                                 fleet_y;
    logic [3:0]                             level;
    logic                                   fleet_cleared;
    logic                                   fleet_landed;
    logic                                   alien_pixel;

    modport master (
        output frame_tick, level_start, scan_x, scan_y, hit_valid, hit_x, hit_y,
        input  hit_ack, alive_matrix, armed_matrix, fleet_x, fleet_y, level,
               fleet_cleared, fleet_landed, alien_pixel
    );

    modport slave (
        input  frame_tick, level_start, scan_x, scan_y, hit_valid, hit_x, hit_y,
        output hit_ack, alive_matrix, armed_matrix, fleet_x, fleet_y, level,
               fleet_cleared, fleet_landed, alien_pixel
    );
endinterface

// File: rtl/fleet_extents.sv
// Extents of the live formation: leftmost/rightmost live column, lowest live row, live count.
// Purely combinational from the alive matrix.
// No flow control.  alive_count is only built with ALIEN_FLEET_SPEEDUP_EN, else tied to zero.
module fleet_extents
    import chip_invaders_pkg::*;
#(
    parameter int NUM_ROWS    = 2,
    parameter int NUM_COLUMNS = 4
) (
    input  logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0] alive,
    output coord_t                               left_col,
    output coord_t                               right_col,
    output coord_t                               low_row,
    output coord_t                               alive_count
);

    logic [NUM_COLUMNS-1:0] col_live;

    // Scan columns and rows; later matches overwrite earlier ones to pick the extreme index.
    always_comb begin
        col_live  = '0;
        left_col  = '0;
        right_col = '0;
        low_row   = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            col_live = col_live | alive[r];
            if (|alive[r]) low_row = coord_t'(r);
        end
        for (int c = NUM_COLUMNS - 1; c >= 0; c--) begin
            if (col_live[c]) left_col = coord_t'(c);
        end
        for (int c = 0; c < NUM_COLUMNS; c++) begin
            if (col_live[c]) right_col = coord_t'(c);
        end
    end

`ifdef ALIEN_FLEET_SPEEDUP_EN
    // Population count feeding the speed-up period.
    always_comb begin
        alive_count = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLUMNS; c++) begin
                alive_count = alive_count + coord_t'(alive[r][c]);
            end
        end
    end
`else
    assign alive_count = '0;
`endif

endmodule

// File: rtl/alien_fleet_controller.sv
// Marching alien formation: edge reversal, drops, bullet hits, cleared/landed status, scan render.
// hit_ack, alive bit update and alien_pixel are one cycle after their inputs; status flags lag state by one.
// No backpressure; optional ALIEN_FLEET_SPEEDUP_EN shortens the step period as aliens die and levels rise.
module alien_fleet_controller
    import chip_invaders_pkg::*;
#(
    parameter int NUM_ROWS        = 2,
    parameter int NUM_COLUMNS     = 4,
    parameter int ALIEN_SPACING_X = 64,
    parameter int ALIEN_SPACING_Y = 32,
    parameter int ALIEN_WIDTH     = 32,
    parameter int ALIEN_HEIGHT    = 16,
    parameter int START_X         = 100,
    parameter int START_Y         = 50,
    parameter int SCREEN_LEFT     = 16,
    parameter int SCREEN_RIGHT    = 624,
    parameter int LANDING_Y       = 400,
    parameter int STEP_X          = 4,
    parameter int STEP_Y          = 8,
    parameter int BASE_PERIOD     = 30,
    parameter int MIN_PERIOD      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    alien_fleet_controller_if.slave  bus
);

    localparam int SHIFT_X = pitch_shift(ALIEN_SPACING_X);
    localparam int SHIFT_Y = pitch_shift(ALIEN_SPACING_Y);

    typedef logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0] grid_t;

    fleet_state_t state, state_next;
    grid_t        alive, armed, kill;
    coord_t       fleet_x, fleet_y, step_cnt, period_last;
    coord_t       left_col, right_col, low_row, alive_count;
    logic         dir_right, hit_ack, cleared, landed, pixel, below;
    logic [3:0]   level;
    logic         tick, step_due, edge_block, all_dead, reached_land;
    logic         reload, accept, move, drop, count_clr, count_inc;
    logic [16:0]  right_next, left_edge, bottom_edge;

    // One-hot mask of the cell whose drawn box contains the point (empty if none).
    function automatic grid_t cell_mask(input coord_t px, input coord_t py,
                                        input coord_t ox, input coord_t oy);
        coord_t rx, ry, col, row;
        grid_t  m;
        rx  = px - ox;
        ry  = py - oy;
        col = rx >> SHIFT_X;
        row = ry >> SHIFT_Y;
        m   = '0;
        if (px >= ox && py >= oy &&
            (rx & coord_t'(ALIEN_SPACING_X - 1)) < coord_t'(ALIEN_WIDTH) &&
            (ry & coord_t'(ALIEN_SPACING_Y - 1)) < coord_t'(ALIEN_HEIGHT)) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int c = 0; c < NUM_COLUMNS; c++) begin
                    if (row == coord_t'(r) && col == coord_t'(c)) m[r][c] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    fleet_extents #(
        .NUM_ROWS    (NUM_ROWS),
        .NUM_COLUMNS (NUM_COLUMNS)
    ) u_extents (
        .alive       (alive),
        .left_col    (left_col),
        .right_col   (right_col),
        .low_row     (low_row),
        .alive_count (alive_count)
    );

`ifdef ALIEN_FLEET_SPEEDUP_EN
    int period;
    // Period shrinks with the surviving fraction and the level, floored at MIN_PERIOD.
    always_comb begin
        period = BASE_PERIOD * int'(alive_count) / (NUM_ROWS * NUM_COLUMNS) - int'(level);
        if (period < MIN_PERIOD) period = MIN_PERIOD;
        period_last = coord_t'(period - 1);
    end
`else
    coord_t unused_alive_count;
    assign unused_alive_count = alive_count;
    assign period_last        = coord_t'(BASE_PERIOD - 1);
`endif

    // Edge and landing tests in 17 bits so large offsets cannot wrap past the limits.
    always_comb begin
        right_next   = 17'(fleet_x) + (17'(right_col) << SHIFT_X) + 17'(ALIEN_WIDTH - 1 + STEP_X);
        left_edge    = 17'(fleet_x) + (17'(left_col) << SHIFT_X);
        bottom_edge  = 17'(fleet_y) + (17'(low_row) << SHIFT_Y) + 17'(ALIEN_HEIGHT - 1);
        reached_land = bottom_edge >= 17'(LANDING_Y);
        edge_block   = dir_right ? (right_next > 17'(SCREEN_RIGHT))
                                 : (left_edge < 17'(SCREEN_LEFT + STEP_X));
        all_dead     = (alive == '0);
        tick         = bus.frame_tick & ~bus.level_start;
        step_due     = tick && (step_cnt >= period_last);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: cleared beats landed, landed beats a step.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, CLEARED, LANDED: if (bus.level_start) state_next = MARCH;
            MARCH: begin
                if (all_dead)                     state_next = CLEARED;
                else if (reached_land)            state_next = LANDED;
                else if (step_due && edge_block)  state_next = DROP;
            end
            DROP:    state_next = MARCH;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: datapath controls for the current state.
    always_comb begin
        reload    = 1'b0;
        accept    = 1'b0;
        move      = 1'b0;
        drop      = 1'b0;
        count_clr = 1'b0;
        count_inc = 1'b0;
        case (state)
            IDLE, CLEARED, LANDED: reload = bus.level_start;
            MARCH: begin
                accept = 1'b1;
                if (!all_dead && !reached_land) begin
                    if (step_due) begin
                        count_clr = 1'b1;
                        move      = !edge_block;
                    end else begin
                        count_inc = tick;
                    end
                end
            end
            DROP: begin
                accept = 1'b1;
                drop   = 1'b1;
            end
            default: ;
        endcase
    end

    // Hit resolution against the pre-move origin.
    always_comb begin
        kill = '0;
        if (accept && bus.hit_valid) kill = cell_mask(bus.hit_x, bus.hit_y, fleet_x, fleet_y) & alive;
    end

    // A column's armed alien is its lowest live one.
    always_comb begin
        armed = '0;
        below = 1'b0;
        for (int c = 0; c < NUM_COLUMNS; c++) begin
            below = 1'b0;
            for (int r = NUM_ROWS - 1; r >= 0; r--) begin
                armed[r][c] = alive[r][c] & ~below;
                below       = below | alive[r][c];
            end
        end
    end

    // Fleet datapath, level counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive     <= '1;
            fleet_x   <= coord_t'(START_X);
            fleet_y   <= coord_t'(START_Y);
            step_cnt  <= '0;
            dir_right <= 1'b1;
            level     <= '0;
            hit_ack   <= 1'b0;
            cleared   <= 1'b0;
            landed    <= 1'b0;
            pixel     <= 1'b0;
        end else begin
            hit_ack <= |kill;
            pixel   <= |(cell_mask(bus.scan_x, bus.scan_y, fleet_x, fleet_y) & alive);
            cleared <= (state == CLEARED) && !bus.level_start;
            landed  <= (state == LANDED) && !bus.level_start;
            if (reload) begin
                alive     <= '1;
                fleet_x   <= coord_t'(START_X);
                fleet_y   <= coord_t'(START_Y);
                step_cnt  <= '0;
                dir_right <= 1'b1;
                level     <= (level == LEVEL_MAX) ? LEVEL_MAX : level + 4'd1;
            end else begin
                alive <= alive & ~kill;
                if (count_clr)      step_cnt <= '0;
                else if (count_inc) step_cnt <= step_cnt + 16'd1;
                if (move) fleet_x <= dir_right ? fleet_x + coord_t'(STEP_X) : fleet_x - coord_t'(STEP_X);
                if (drop) begin
                    fleet_y   <= fleet_y + coord_t'(STEP_Y);
                    dir_right <= ~dir_right;
                end
            end
        end
    end

    assign bus.alive_matrix  = alive;
    assign bus.armed_matrix  = armed;
    assign bus.fleet_x       = fleet_x;
    assign bus.fleet_y       = fleet_y;
    assign bus.level         = level;
    assign bus.hit_ack       = hit_ack;
    assign bus.fleet_cleared = cleared;
    assign bus.fleet_landed  = landed;
    assign bus.alien_pixel   = pixel;

endmodule

// File: doc/alien_fleet_controller.md
# alien_fleet_controller

Parametrised alien formation engine: a grid of NUM_ROWS × NUM_COLUMNS aliens that marches sideways, drops and reverses at the playfield edges, and accepts bullet hits. It also reports the cleared and landed conditions and renders the fleet into the VGA scan stream. It sits between the game-state controller (level start, frame tick) and the pixel mixer. It supersedes the fixed, non-moving formation with a position register, edge-aware marching, hit resolution and per-level speed-up.

## Interface
- NUM_ROWS, 2: alien rows (1–8)
- NUM_COLUMNS, 4: alien columns (1–16)
- ALIEN_SPACING_X, 64: horizontal cell pitch in pixels; power of two
- ALIEN_SPACING_Y, 32: vertical cell pitch in pixels; power of two
- ALIEN_WIDTH, 32 / ALIEN_HEIGHT, 16: drawn box within each cell, anchored at the cell's top-left corner
- START_X, 100 / START_Y, 50: fleet origin after reset and after each level_start
- SCREEN_LEFT, 16 / SCREEN_RIGHT, 624: march limits, inclusive pixel columns
- LANDING_Y, 400: a live alien bottom edge ≥ this value ends the game
- STEP_X, 4 / STEP_Y, 8: march step and drop step, in pixels
- BASE_PERIOD, 30: frame ticks per step when the speed-up is disabled or the fleet is full
- MIN_PERIOD, 2: speed-up floor
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse once per video frame
- level_start  in  1  one-cycle pulse; reloads the fleet and starts marching
- scan_x, scan_y  in  16 each  current VGA pixel
- hit_valid  in  1  bullet position query
- hit_x, hit_y  in  16 each  bullet position
- hit_ack  out  1  one-cycle pulse: the query killed an alien
- alive_matrix  out  [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  live aliens
- armed_matrix  out  same  lowest live alien in each column
- fleet_x, fleet_y  out  16 each  current fleet origin
- level  out  4  current level, saturating at 15
- fleet_cleared  out  1  level-sensitive: all aliens dead
- fleet_landed  out  1  level-sensitive: invasion reached LANDING_Y
- alien_pixel  out  1  scan pixel belongs to a live alien

## Operation
- FSM states: IDLE, MARCH, DROP, CLEARED, LANDED.
- Reset state: IDLE. alive_matrix is all 1. fleet_x/fleet_y equal START_X/START_Y. Direction is right. level is 0. hit_ack, fleet_cleared, fleet_landed and alien_pixel are all 0.
- level_start in IDLE, CLEARED or LANDED:
  - alive_matrix reloads to all 1 and the origin returns to START.
  - The step counter clears and direction is set to right.
  - level increments, except on the first start after reset, which sets level to 1.
  - FSM enters MARCH.
- level_start is ignored in MARCH and DROP.
- MARCH: the step counter increments on each frame_tick. When the count reaches period-1 a step occurs and the counter clears.
  - Step right: if the right edge of the rightmost live column plus STEP_X would exceed SCREEN_RIGHT, go to DROP. Otherwise fleet_x += STEP_X.
  - Step left: same rule mirrored against SCREEN_LEFT.
- DROP: for one cycle, fleet_y += STEP_Y, direction flips, and the FSM returns to MARCH.
- After any move, if the bottom edge of the lowest live row is ≥ LANDING_Y, go to LANDED.
- When alive_matrix becomes all 0, go to CLEARED, which takes priority over LANDED.
- Hit resolution:
  - rel_x = hit_x − fleet_x; column = rel_x >> log2(ALIEN_SPACING_X). rel_y and row are computed the same way.
  - A kill requires all of: the point lies inside the ALIEN_WIDTH × ALIEN_HEIGHT box; row and column are in range; hit_x ≥ fleet_x and hit_y ≥ fleet_y; the cell is alive.
  - Hits are accepted in MARCH and DROP only.
- armed_matrix[r][c] = alive[r][c] and no alive[r'][c] for any r' > r. It is combinational from alive_matrix.
- Arithmetic is unsigned 16-bit. Comparisons against SCREEN_RIGHT and LANDING_Y use 17-bit sums so they cannot wrap.

## Timing
- hit_ack and the cleared alive bit are both visible in the cycle after hit_valid.
- A hit in the same cycle as a step is resolved against the pre-step origin.
- Back-to-back hit_valid cycles are each resolved independently.
- alien_pixel is registered: one cycle of latency after scan_x/scan_y.
- A frame_tick coincident with level_start is discarded.
- fleet_cleared and fleet_landed rise in the cycle after the FSM enters the corresponding state. They hold until level_start or rst.
- rst during any state returns all outputs to their reset values asynchronously.

## Configuration
- ALIEN_FLEET_SPEEDUP_EN defined: period = max(MIN_PERIOD, BASE_PERIOD × alive_count / (NUM_ROWS × NUM_COLUMNS) − level). The period is recomputed after each kill and takes effect at the next comparison.
- ALIEN_FLEET_SPEEDUP_EN undefined: period is constant BASE_PERIOD, and the alive-count logic is not built.

## Structure
- Package chip_invaders_pkg holds: fleet_state_t (FSM enum), coord_t (logic [15:0]), and a clog2-based shift helper constant.
- One sub-module, fleet_extents, is combinational from alive_matrix. It outputs:
  - leftmost and rightmost live column;
  - lowest live row;
  - alive_count, whose port is tied off when the macro is undefined.

## Test plan
- Reset then level_start → level=1, fleet_x=100, MARCH. After 30 frame_ticks, fleet_x=104 (macro off).
- Default parameters: right edge = fleet_x + 3×64 + 32 − 1. The step that would take this past 624 → one DROP cycle, fleet_y=58, direction left, fleet_x unchanged.
- hit_valid with (100, 50) at the start position → next cycle hit_ack=1 and alive[0][0]=0. Repeating the same query gives hit_ack=0. A hit at (140, 50), which falls in the gap between cells, gives hit_ack=0.
- Kill column 3 entirely → right-edge reversal now uses column 2. Kill all 8 aliens → fleet_cleared=1. level_start → level=2 and alive all 1.
- Force marching until the lowest row bottom edge is ≥ 400 → fleet_landed=1 and further frame_ticks do not move the fleet. Assert rst mid-DROP → all outputs at reset values immediately.
- With the macro on, kill 4 of 8 aliens at level 1 → period = max(2, 15 − 1) = 14 ticks per step.
